program_memory_arbiter: RTL
===========================

Name: program_memory_arbiter

Overview:
- Shares one 2-cycle-latency read port of program_memory (consumer side A or B) between NUM_REQ requesters, e.g. CPU fetch, sprite/asset loader and debug reader.
- Round-robin arbitration at burst granularity; a burst is 1..16 consecutive words.
- An issue FSM generates word addresses; a tag pipeline routes each returned word to its owner.
- Sits between the requesters and program_memory_bus.CONSUMER_A/CONSUMER_B.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 2, cycles from mem_read_request to mem_data_valid; must match program_memory.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester request; held with addr/len until req_ready
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed byte start address, slice i = requester i
- req_len  input  NUM_REQ*4  packed beats minus 1 (0 = 1 word, 15 = 16 words)
- req_ready  output  NUM_REQ  one-hot one-cycle pulse: request accepted, burst starts
- resp_valid  output  NUM_REQ  one-hot: resp_data belongs to requester i
- resp_data  output  DATA_WIDTH  returned word, shared by all requesters
- resp_last  output  1  final word of a burst
- mem_addr  output  ADDR_WIDTH  to bus.addr
- mem_read_request  output  1  to bus.read_request
- mem_instr  input  DATA_WIDTH  from bus.instr
- mem_data_valid  input  1  from bus.data_valid
- busy  output  1  burst in progress or words in flight
- protocol_err  output  1  sticky: mem_data_valid disagrees with tag pipe
- perf_grants  output  NUM_REQ*32  see Optional Feature
- perf_waits  output  NUM_REQ*32  see Optional Feature

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_last=0, mem_addr=0, mem_read_request=0, busy=0, protocol_err=0, rr pointer=NUM_REQ-1, state=IDLE, tag pipe all invalid.
- FSM states: IDLE, BURST.
- IDLE with any req_valid:
  - Grant the first requester at or after rr_ptr+1 (mod NUM_REQ) and set rr_ptr to the winner.
  - In the same cycle: req_ready[win]=1; issue beat 0 with mem_addr = req_addr[win] with bits [1:0] forced to 0; mem_read_request=1.
  - Latch base address, len and id.
  - len==0: stay IDLE. Otherwise go to BURST with beat counter=1.
- BURST: issue one beat per cycle at base+4*beat, wrapping modulo 2^ADDR_WIDTH. After beat==len, return to IDLE.
  - No bubble between bursts: IDLE may grant in the cycle after the last beat.
  - req_valid of other requesters is ignored during BURST.
  - The owner's req_valid/req_addr are don't-care after its req_ready.
- Issued outputs are combinational from state and latched registers. mem_read_request is low in cycles with nothing to issue.
- Tag pipe:
  - READ_LATENCY stages of {valid, id, last}, shifted every cycle.
  - The stage-0 entry is written on every issue.
  - At the output stage: resp_valid[id] = tag.valid & mem_data_valid, resp_data = mem_instr, resp_last = tag.last. All combinational, zero added latency.
- Requester-visible latency: first word at cycle t+READ_LATENCY after req_ready at cycle t. Words arrive on consecutive cycles. Responses cannot be stalled.
- protocol_err: set when tag.valid != mem_data_valid at the output stage. Cleared only by reset.
- busy = (state==BURST) | any tag.valid.
- Reset mid-burst: the burst is abandoned and the tag pipe is cleared. Words already in flight are dropped: resp_valid stays 0 even if mem_data_valid arrives. protocol_err ignores the first READ_LATENCY cycles after reset.
- A requester that deasserts req_valid before req_ready simply loses its turn; no error.

Optional Feature:
- Macro: PM_ARB_PERF_EN.
- Defined:
  - perf_grants[i] increments on each req_ready[i].
  - perf_waits[i] increments each cycle with req_valid[i] & !req_ready[i].
  - Both are 32-bit, saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counters; both ports are tied to 0.

Decomposition:
- Package pm_arb_pkg:
  - pm_arb_state_t enum {IDLE, BURST}.
  - pm_tag_t struct {valid, id[$clog2(NUM_REQ)], last}; id width is fixed at 3 bits for NUM_REQ<=8.
  - PM_WORD_BYTES=4.
  - PM_LEN_WIDTH=4.
- Sub-module rr_arbiter: req vector and pointer in, one-hot grant and index out, purely combinational.

Test Plan:
- R0 single word, req_addr=0x103, len=0 -> req_ready[0] at t; mem_addr=0x100 at t; resp_valid[0]=1, resp_last=1 at t+2 with mem word 0x40.
- R1 len=3 at 0x200 -> mem_addr 0x200,0x204,0x208,0x20C on t..t+3; four responses t+2..t+5; resp_last only on the fourth.
- All three requesters held with len=0 from reset -> grants in order 0,1,2,0,1,2 on consecutive cycles; no idle cycle on the mem port.
- R2 at 0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_in pulsed in the cycle after R0 issues beat 2 of 8 -> no resp_valid afterwards; busy=0 and protocol_err=0 one cycle after reset.
- Model drives mem_data_valid with no issue -> protocol_err rises and stays set. With PM_ARB_PERF_EN, after R1 waits 5 cycles -> perf_waits[1]=5 and perf_grants[1]=1.

Source files
------------

// File: rtl/program_memory_arbiter_pkg.sv
// pm_arb_pkg: shared types and constants for program_memory_arbiter.
// No ports; imported by program_memory_arbiter and rr_arbiter.
package pm_arb_pkg;
    localparam int PM_WORD_BYTES = 4;
    localparam int PM_LEN_WIDTH  = 4;
    localparam int PM_ID_WIDTH   = 3;
    typedef enum logic {IDLE, BURST} pm_arb_state_t;
    typedef struct packed {
        logic                   valid;
        logic [PM_ID_WIDTH-1:0] id;
        logic                   last;
    } pm_tag_t;
endpackage

// File: rtl/program_memory_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr.
// Ports: req (request vector), ptr (last winner), grant (one-hot), idx (winner), any (some request).
module rr_arbiter
    import pm_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
)(
    input  logic [NUM_REQ-1:0]     req,
    input  logic [PM_ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]     grant,
    output logic [PM_ID_WIDTH-1:0] idx,
    output logic                   any
);
    always_comb begin
        int best;
        best = NUM_REQ;
        idx  = '0;
        // distance from ptr+1 going upward; smallest distance wins
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && ((i + 2 * NUM_REQ - int'(ptr) - 1) % NUM_REQ) < best) begin
                best = (i + 2 * NUM_REQ - int'(ptr) - 1) % NUM_REQ;
                idx  = PM_ID_WIDTH'(i);
            end
        end
        any   = |req;
        grant = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares one fixed-latency program_memory read port between
// NUM_REQ requesters with burst-granular round-robin and a tag pipe for returns.
// Ports: clk_in/rst_in; req_valid/req_addr/req_len/req_ready (requests);
// resp_valid/resp_data/resp_last (returns); mem_addr/mem_read_request/mem_instr/
// mem_data_valid (memory bus); busy, protocol_err, perf_grants/perf_waits.
// Optional macro PM_ARB_PERF_EN enables saturating per-requester grant/wait counters.
module program_memory_arbiter
    import pm_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
)(
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*PM_LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             resp_last,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_read_request,
    input  logic [DATA_WIDTH-1:0]            mem_instr,
    input  logic                             mem_data_valid,
    output logic                             busy,
    output logic                             protocol_err,
    output logic [NUM_REQ*32-1:0]            perf_grants,
    output logic [NUM_REQ*32-1:0]            perf_waits
);
    localparam int BW = $clog2(READ_LATENCY + 1);

    pm_arb_state_t           state_q, state_d;
    logic [PM_ID_WIDTH-1:0]  rr_q, rr_d, id_q, id_d, win, issue_id;
    logic [ADDR_WIDTH-1:0]   base_q, base_d, win_addr;
    logic [PM_LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d, win_len;
    logic [BW-1:0]           blank_q, blank_d;
    logic                    err_q, err_d, any_req, issue_last, rsp;
    logic [NUM_REQ-1:0]      grant;
    pm_tag_t                 tag_q [READ_LATENCY];
    pm_tag_t                 tag_d [READ_LATENCY];
    pm_tag_t                 out_tag;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (grant),
        .idx   (win),
        .any   (any_req)
    );

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr = (win == PM_ID_WIDTH'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : win_addr;
            win_len  = (win == PM_ID_WIDTH'(i)) ? req_len[i*PM_LEN_WIDTH +: PM_LEN_WIDTH] : win_len;
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        base_d           = base_q;
        len_d            = len_q;
        id_d             = id_q;
        beat_d           = beat_q;
        mem_read_request = 1'b0;
        mem_addr         = '0;
        issue_last       = 1'b0;
        issue_id         = id_q;
        req_ready        = '0;
        if (state_q == BURST) begin
            mem_read_request = 1'b1;
            mem_addr         = base_q + ADDR_WIDTH'({beat_q, 2'b00});
            issue_last       = beat_q == len_q;
            beat_d           = beat_q + 1'b1;
            state_d          = issue_last ? IDLE : BURST;
        end else if (any_req) begin
            // beat 0 goes out in the grant cycle itself
            req_ready        = grant;
            mem_read_request = 1'b1;
            mem_addr         = win_addr & ~ADDR_WIDTH'(PM_WORD_BYTES - 1);
            issue_last       = win_len == '0;
            issue_id         = win;
            base_d           = mem_addr;
            len_d            = win_len;
            id_d             = win;
            rr_d             = win;
            beat_d           = PM_LEN_WIDTH'(1);
            state_d          = issue_last ? IDLE : BURST;
        end
    end

    always_comb begin
        tag_d[0] = {mem_read_request, issue_id, issue_last};
        for (int k = 1; k < READ_LATENCY; k++) tag_d[k] = tag_q[k-1];
        out_tag    = tag_q[READ_LATENCY-1];
        rsp        = out_tag.valid & mem_data_valid;
        resp_valid = rsp ? NUM_REQ'(1) << out_tag.id : '0;
        resp_data  = rsp ? mem_instr : '0;
        resp_last  = rsp & out_tag.last;
        // words issued before a reset may still land during the blanking window
        err_d      = err_q | (blank_q == '0 && out_tag.valid != mem_data_valid);
        blank_d    = blank_q == '0 ? '0 : blank_q - 1'b1;
        busy       = state_q == BURST;
        for (int k = 0; k < READ_LATENCY; k++) busy = busy | tag_q[k].valid;
        protocol_err = err_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            rr_q    <= PM_ID_WIDTH'(NUM_REQ - 1);
            id_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            blank_q <= BW'(READ_LATENCY);
            for (int k = 0; k < READ_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            for (int k = 0; k < READ_LATENCY; k++) tag_q[k] <= tag_d[k];
        end
    end

`ifdef PM_ARB_PERF_EN
    logic [31:0] grants_q [NUM_REQ];
    logic [31:0] grants_d [NUM_REQ];
    logic [31:0] waits_q  [NUM_REQ];
    logic [31:0] waits_d  [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grants_d[i] = (req_ready[i] && grants_q[i] != '1) ? grants_q[i] + 32'd1 : grants_q[i];
            waits_d[i]  = (req_valid[i] && !req_ready[i] && waits_q[i] != '1) ? waits_q[i] + 32'd1 : waits_q[i];
            perf_grants[i*32 +: 32] = grants_q[i];
            perf_waits[i*32 +: 32]  = waits_q[i];
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grants_q[i] <= rst_in ? '0 : grants_d[i];
            waits_q[i]  <= rst_in ? '0 : waits_d[i];
        end
    end
`else
    assign perf_grants = '0;
    assign perf_waits  = '0;
`endif
endmodule
